// File: rtl/fifo.sv
// Single-clock FIFO of SIZE words, registered show-ahead read data and accept acks.
// Latency: a write accepted at edge N is visible on rddata after edge N+1; acks arrive one edge after the request.
// Backpressure: writes are refused while full and reads while empty (registered flags); refused requests are dropped.
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int SIZE       = 3,
  localparam int CW        = $clog2(SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rden,
  output logic [DATA_WIDTH-1:0] rddata,
  output logic                  rddata_valid,
  output logic                  rddone,
  input  logic                  wren,
  input  logic [DATA_WIDTH-1:0] wrdata,
  output logic                  wrdone,
  output logic                  empty,
  output logic                  full,
  output logic [CW-1:0]         num_used,
  output logic [CW-1:0]         num_free
);

  // Pointer width; a single-entry FIFO still needs one bit to hold index 0.
  localparam int PW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(SIZE - 1);
  localparam logic [CW-1:0] SIZE_CNT = CW'(SIZE);

  logic [DATA_WIDTH-1:0] mem [SIZE];
  logic [PW-1:0]         wp;
  logic [PW-1:0]         rp;
  logic [CW-1:0]         cnt;
  logic                  wr_acc;
  logic                  rd_acc;

  // Pointers wrap at SIZE-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PW'(1);
  endfunction

  // Status flags come purely from the registered count.
  always_comb begin
    empty    = (cnt == '0);
    full     = (cnt == SIZE_CNT);
    num_used = cnt;
    num_free = SIZE_CNT - cnt;
  end

  // Accept decisions use the flags as they were before the edge, so a
  // simultaneous read never makes room for a write and vice versa.
  always_comb begin
    wr_acc = wren && !full;
    rd_acc = rden && !empty;
  end

  // Storage array is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wp] <= wrdata;
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_acc) begin
        wp <= ptr_next(wp);
      end
      if (rd_acc) begin
        rp <= ptr_next(rp);
      end
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Registered read data and acknowledges, refreshed every edge; rddata
  // samples the head before the pointer moves, so it is the popped word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rddata       <= '0;
      rddata_valid <= 1'b0;
      rddone       <= 1'b0;
      wrdone       <= 1'b0;
    end else begin
      rddata       <= mem[rp];
      rddata_valid <= !empty;
      rddone       <= rd_acc;
      wrdone       <= wr_acc;
    end
  end

endmodule

// File: tb/tb_fifo.sv
// Directed bench for fifo: queue-based reference model checked every cycle plus literal expectations.
// Latency: model updates on each clk rise; outputs compared on the falling edge.
// Backpressure: model refuses writes at SIZE entries and reads at zero entries, like the design.
module tb_fifo;

  localparam int DW   = 8;
  localparam int SIZE = 3;
  localparam int CW   = $clog2(SIZE + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rden = 1'b0;
  logic          wren = 1'b0;
  logic [DW-1:0] wrdata = '0;
  logic [DW-1:0] rddata;
  logic          rddata_valid;
  logic          rddone;
  logic          wrdone;
  logic          empty;
  logic          full;
  logic [CW-1:0] num_used;
  logic [CW-1:0] num_free;

  int checks = 0;
  int failures = 0;

  fifo #(.DATA_WIDTH(DW), .SIZE(SIZE)) dut (
    .clk(clk), .reset(reset), .rden(rden), .rddata(rddata),
    .rddata_valid(rddata_valid), .rddone(rddone), .wren(wren),
    .wrdata(wrdata), .wrdone(wrdone), .empty(empty), .full(full),
    .num_used(num_used), .num_free(num_free)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus expected registered outputs.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rddata;
  logic          m_valid;
  logic          m_rddone;
  logic          m_wrdone;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_rddata = '0;
      m_valid  = 1'b0;
      m_rddone = 1'b0;
      m_wrdone = 1'b0;
    end else begin
      automatic bit wr_ok = wren && (q.size() < SIZE);
      automatic bit rd_ok = rden && (q.size() != 0);
      m_valid  = (q.size() != 0);
      if (m_valid) m_rddata = q[0];
      m_rddone = rd_ok;
      m_wrdone = wr_ok;
      if (rd_ok) void'(q.pop_front());
      if (wr_ok) q.push_back(wrdata);
    end
  end

  // Every-cycle comparison against the model while out of reset.
  always @(negedge clk) begin
    if (reset) begin
      chk("m_empty", 32'(empty), 32'(q.size() == 0));
      chk("m_full", 32'(full), 32'(q.size() == SIZE));
      chk("m_num_used", 32'(num_used), 32'(q.size()));
      chk("m_num_free", 32'(num_free), 32'(SIZE - q.size()));
      chk("m_valid", 32'(rddata_valid), 32'(m_valid));
      chk("m_rddone", 32'(rddone), 32'(m_rddone));
      chk("m_wrdone", 32'(wrdone), 32'(m_wrdone));
      if (m_valid) chk("m_rddata", 32'(rddata), 32'(m_rddata));
    end
  end

  // Drive one set of requests, let the next edge sample them, settle 2 time units.
  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
    wren   = w;
    wrdata = d;
    rden   = r;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_used"}, 32'(num_used), 32'd0);
    chk({tag, "_free"}, 32'(num_free), 32'd3);
    chk({tag, "_valid"}, 32'(rddata_valid), 32'd0);
    chk({tag, "_rddone"}, 32'(rddone), 32'd0);
    chk({tag, "_wrdone"}, 32'(wrdone), 32'd0);
    chk({tag, "_rddata"}, 32'(rddata), 32'd0);
  endtask

  initial begin
    #1;
    chk_reset_vals("por");
    #11 reset = 1'b1;
    @(posedge clk);
    #2;

    // Idle after reset.
    cyc(0, 8'd0, 0);
    chk("idle_empty", 32'(empty), 32'd1);
    chk("idle_free", 32'(num_free), 32'd3);
    chk("idle_valid", 32'(rddata_valid), 32'd0);

    // Fill with 1,2,3.
    cyc(1, 8'd1, 0);
    chk("w1_wrdone", 32'(wrdone), 32'd1);
    chk("w1_used", 32'(num_used), 32'd1);
    cyc(1, 8'd2, 0);
    chk("w2_used", 32'(num_used), 32'd2);
    chk("w2_valid", 32'(rddata_valid), 32'd1);
    chk("w2_rddata", 32'(rddata), 32'd1);
    cyc(1, 8'd3, 0);
    chk("w3_used", 32'(num_used), 32'd3);
    chk("w3_full", 32'(full), 32'd1);

    // Read + write while full: write refused.
    cyc(1, 8'd4, 1);
    chk("rwf_rddone", 32'(rddone), 32'd1);
    chk("rwf_rddata", 32'(rddata), 32'd1);
    chk("rwf_wrdone", 32'(wrdone), 32'd0);
    chk("rwf_used", 32'(num_used), 32'd2);
    cyc(1, 8'd4, 1);
    chk("rw_wrdone", 32'(wrdone), 32'd1);
    chk("rw_used", 32'(num_used), 32'd2);
    chk("rw_rddata", 32'(rddata), 32'd2);

    // Drain: 3 then 4 (4 sits at wrapped index 0).
    cyc(0, 8'd0, 1);
    chk("d3_rddata", 32'(rddata), 32'd3);
    chk("d3_used", 32'(num_used), 32'd1);
    cyc(0, 8'd0, 1);
    chk("d4_rddone", 32'(rddone), 32'd1);
    chk("d4_rddata", 32'(rddata), 32'd4);
    chk("d4_empty", 32'(empty), 32'd1);
    cyc(0, 8'd0, 1);
    chk("de_rddone", 32'(rddone), 32'd0);
    chk("de_valid", 32'(rddata_valid), 32'd0);

    // Read + write on empty: no pass-through.
    cyc(1, 8'd5, 1);
    chk("rwe_wrdone", 32'(wrdone), 32'd1);
    chk("rwe_rddone", 32'(rddone), 32'd0);
    chk("rwe_used", 32'(num_used), 32'd1);
    chk("rwe_valid", 32'(rddata_valid), 32'd0);
    cyc(0, 8'd0, 0);
    chk("rwe2_rddata", 32'(rddata), 32'd5);
    chk("rwe2_valid", 32'(rddata_valid), 32'd1);

    // Second entry, then asynchronous reset mid-cycle.
    cyc(1, 8'd6, 0);
    chk("pre_rst_used", 32'(num_used), 32'd2);
    chk("pre_rst_wrdone", 32'(wrdone), 32'd1);
    wren = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk_reset_vals("arst");
    #3 reset = 1'b1;
    @(posedge clk);
    #2;

    // Mixed traffic checked by the model only; includes overfill and underflow.
    for (int i = 0; i < 48; i++) begin
      cyc(logic'((i % 3) != 2) && (i < 36), 8'(8'h10 + i), logic'((i % 5) >= 3) || (i >= 30));
    end
    cyc(0, 8'd0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
